// File: rtl/hc_pkg.sv
// Shared opcodes, FSM state encoding and NZCV bit positions for the execute stage.
package hc_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_ASR = 4'h8;
  localparam logic [3:0] OP_MOV = 4'h9;
  localparam logic [3:0] OP_MUL = 4'hA;
  localparam logic [3:0] OP_CMP = 4'hB;
  localparam logic [3:0] OP_ST  = 4'hC;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ex_mul_seq.sv
// Iterative shift-add multiplier: one partial-product add per cycle, STEPS cycles per multiply.
// done_o holds with the full product until clear_i or a new start_i.
module ex_mul_seq #(
  parameter int WIDTH = 16,
  parameter int STEPS = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic               clear_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               last_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CNT_W = $clog2(STEPS);

  logic [WIDTH-1:0] hi_q, lo_q, mcand_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q;
  logic [WIDTH:0]   sum;

  // Multiplier bits retire from lo_q[0]; the product grows into hi_q and shifts down into lo_q.
  assign sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (start_i) begin
      hi_q    <= '0;
      lo_q    <= b_i;
      mcand_q <= a_i;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else if (clear_i) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (busy_q) begin
      hi_q  <= sum[WIDTH:1];
      lo_q  <= {sum[0], lo_q[WIDTH-1:1]};
      cnt_q <= cnt_q + 1'b1;
      if (last_o) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  assign busy_o    = busy_q;
  assign last_o    = busy_q && (cnt_q == CNT_W'(STEPS - 1));
  assign done_o    = done_q;
  assign product_o = {hi_q, lo_q};

endmodule

// File: rtl/execute.sv
// 16-bit execute stage: inline ALU and NZCV flags, sequential multiplier, EX/WB output register.
// Single-cycle ops complete at the accept edge; MUL blocks new work until its result is written out.
module execute
  import hc_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int IDX_W     = 5,
  parameter int MUL_STEPS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_ex_valid,
  output logic             ex_ready,
  input  logic [3:0]       id_ex_op,
  input  logic [WIDTH-1:0] id_ex_a,
  input  logic [WIDTH-1:0] id_ex_b,
  input  logic [IDX_W-1:0] id_ex_reg_idx_dst,
  input  logic             id_ex_set_flags,
  input  logic             ex_flush,
  input  logic             wb_stall,
  output logic             ex_wb_valid,
  output logic [WIDTH-1:0] ex_wb_result,
  output logic [3:0]       ex_wb_nzcv,
  output logic [IDX_W-1:0] ex_wb_reg_idx_dst,
  output logic             ex_wb_reg_w,
  output logic             ex_wb_mem_w,
  output logic [WIDTH-1:0] ex_wb_mem_addr,
  output logic [WIDTH-1:0] ex_wb_mem_data
);

  state_e state_q, state_d;

  logic             valid_q, reg_w_q, mem_w_q;
  logic [WIDTH-1:0] result_q, mem_addr_q, mem_data_q;
  logic [3:0]       wb_nzcv_q, flags_q;
  logic [IDX_W-1:0] dst_q, pend_dst_q;
  logic             pend_sf_q;

  logic out_free, accept, mul_start, load_alu, load_mul;
  logic mul_busy, mul_last, mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign out_free = !valid_q || !wb_stall;
  assign ex_ready = (state_q == S_IDLE) && out_free && !ex_flush;
  assign accept   = id_ex_valid && ex_ready;

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    load_alu  = 1'b0;
    load_mul  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (id_ex_op == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = S_MUL;
          end else begin
            load_alu = 1'b1;
          end
        end
      end
      S_MUL:   if (mul_busy && mul_last) state_d = S_DONE;
      S_DONE: begin
        if (out_free && mul_done) begin
          load_mul = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (ex_flush) begin
      state_d  = S_IDLE;
      load_mul = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  ex_mul_seq #(.WIDTH(WIDTH), .STEPS(MUL_STEPS)) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start_i   (mul_start),
    .clear_i   (ex_flush || load_mul),
    .a_i       (id_ex_a),
    .b_i       (id_ex_b),
    .busy_o    (mul_busy),
    .last_o    (mul_last),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  logic [WIDTH:0]   sum, diff, shl, shr, asr;
  logic [3:0]       sh;
  logic [WIDTH-1:0] alu_res, alu_addr, alu_data;
  logic             alu_c, alu_v, alu_rw, alu_mw;
  logic [3:0]       alu_nzcv, mul_nzcv;

  assign sh   = id_ex_b[3:0];
  assign sum  = {1'b0, id_ex_a} + {1'b0, id_ex_b};
  assign diff = {1'b0, id_ex_a} - {1'b0, id_ex_b};
  // One extra bit beside the operand catches the last bit shifted out; zero shift leaves it 0.
  assign shl  = {1'b0, id_ex_a} << sh;
  assign shr  = {id_ex_a, 1'b0} >> sh;
  assign asr  = $signed({id_ex_a, 1'b0}) >>> sh;

  always_comb begin
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    alu_rw   = 1'b1;
    alu_mw   = 1'b0;
    alu_addr = '0;
    alu_data = '0;
    case (id_ex_op)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (id_ex_a[WIDTH-1] == id_ex_b[WIDTH-1]) && (sum[WIDTH-1] != id_ex_a[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = !diff[WIDTH];
        alu_v   = (id_ex_a[WIDTH-1] != id_ex_b[WIDTH-1]) && (diff[WIDTH-1] != id_ex_a[WIDTH-1]);
        alu_rw  = (id_ex_op != OP_CMP);
      end
      OP_AND: alu_res = id_ex_a & id_ex_b;
      OP_OR:  alu_res = id_ex_a | id_ex_b;
      OP_XOR: alu_res = id_ex_a ^ id_ex_b;
      OP_NOT: alu_res = ~id_ex_a;
      OP_MOV: alu_res = id_ex_b;
      OP_SHL: begin
        alu_res = shl[WIDTH-1:0];
        alu_c   = shl[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr[WIDTH:1];
        alu_c   = shr[0];
      end
      OP_ASR: begin
        alu_res = asr[WIDTH:1];
        alu_c   = asr[0];
      end
      OP_ST: begin
        alu_rw   = 1'b0;
        alu_mw   = 1'b1;
        alu_addr = id_ex_a;
        alu_data = id_ex_b;
      end
      default: alu_rw = 1'b0;
    endcase
  end

  always_comb begin
    alu_nzcv         = '0;
    alu_nzcv[FLAG_N] = alu_res[WIDTH-1];
    alu_nzcv[FLAG_Z] = (alu_res == '0);
    alu_nzcv[FLAG_C] = alu_c;
    alu_nzcv[FLAG_V] = alu_v;
    mul_nzcv         = '0;
    mul_nzcv[FLAG_N] = mul_prod[WIDTH-1];
    mul_nzcv[FLAG_Z] = (mul_prod[WIDTH-1:0] == '0);
    mul_nzcv[FLAG_C] = (mul_prod[2*WIDTH-1:WIDTH] != '0);
    mul_nzcv[FLAG_V] = (mul_prod[2*WIDTH-1:WIDTH] != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_dst_q <= '0;
      pend_sf_q  <= 1'b0;
    end else if (mul_start) begin
      pend_dst_q <= id_ex_reg_idx_dst;
      pend_sf_q  <= id_ex_set_flags;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      result_q   <= '0;
      wb_nzcv_q  <= '0;
      flags_q    <= '0;
      dst_q      <= '0;
      reg_w_q    <= 1'b0;
      mem_w_q    <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else if (ex_flush) begin
      valid_q <= 1'b0;
    end else if (load_alu) begin
      valid_q    <= 1'b1;
      result_q   <= alu_res;
      wb_nzcv_q  <= id_ex_set_flags ? alu_nzcv : flags_q;
      dst_q      <= id_ex_reg_idx_dst;
      reg_w_q    <= alu_rw;
      mem_w_q    <= alu_mw;
      mem_addr_q <= alu_addr;
      mem_data_q <= alu_data;
      if (id_ex_set_flags) flags_q <= alu_nzcv;
    end else if (load_mul) begin
      valid_q    <= 1'b1;
      result_q   <= mul_prod[WIDTH-1:0];
      wb_nzcv_q  <= pend_sf_q ? mul_nzcv : flags_q;
      dst_q      <= pend_dst_q;
      reg_w_q    <= 1'b1;
      mem_w_q    <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      if (pend_sf_q) flags_q <= mul_nzcv;
    end else if (out_free) begin
      valid_q <= 1'b0;
    end
  end

  assign ex_wb_valid       = valid_q;
  assign ex_wb_result      = result_q;
  assign ex_wb_nzcv        = wb_nzcv_q;
  assign ex_wb_reg_idx_dst = dst_q;
  assign ex_wb_reg_w       = reg_w_q;
  assign ex_wb_mem_w       = mem_w_q;
  assign ex_wb_mem_addr    = mem_addr_q;
  assign ex_wb_mem_data    = mem_data_q;

endmodule
